// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler bus: game events in, slot positions/types and speed out.
// The scheduler uses the master side; the renderer/collision side uses slave.
interface obstacle_scheduler_if;
    logic [1:0] game_tick;
    logic       start_pulse;
    logic       crash;
    logic [1:0] obs_valid;
    logic [7:0] obs0_x;
    logic [7:0] obs1_x;
    logic [1:0] obs0_type;
    logic [1:0] obs1_type;
    logic [2:0] speed;
    logic       running;

    modport master (
        input  game_tick, start_pulse, crash,
        output obs_valid, obs0_x, obs1_x, obs0_type, obs1_type, speed, running
    );

    modport slave (
        output game_tick, start_pulse, crash,
        input  obs_valid, obs0_x, obs1_x, obs0_type, obs1_type, speed, running
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Two-slot obstacle sequencer for the dino game: LFSR-driven spawning with a
// minimum gap, per-frame scrolling, and a speed ramp tied to elapsed run time.
module obstacle_scheduler #(
    parameter logic [7:0] X_START    = 8'd160,
    parameter logic [7:0] MIN_GAP    = 8'd48,
    parameter logic [9:0] SPEED_STEP = 10'd512,
    parameter logic [2:0] MAX_SPEED  = 3'd4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      valid_q, valid_d;
    logic [1:0][7:0] x_q, x_d;
    logic [1:0][1:0] type_q, type_d;
    logic [2:0]      speed_q, speed_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [7:0]      gap_q, gap_d;
    logic [9:0]      tick_cnt_q, tick_cnt_d;
    logic [8:0]      gap_sum;
    logic            spawn_slot;
    logic            tick;
    logic            unused_half_tick;

    assign tick             = bus.game_tick[0];
    assign unused_half_tick = bus.game_tick[1];

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        x_d        = x_q;
        type_d     = type_q;
        speed_d    = speed_q;
        gap_d      = gap_q;
        tick_cnt_d = tick_cnt_q;
        spawn_slot = 1'b0;
        gap_sum    = {1'b0, gap_q} + {6'd0, speed_q};
        // The LFSR free-runs on frame ticks in every state so idle time adds entropy.
        lfsr_d     = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                          : lfsr_q;

        case (state_q)
            IDLE: begin
                valid_d    = '0;
                x_d        = '0;
                type_d     = '0;
                speed_d    = 3'd1;
                gap_d      = '0;
                tick_cnt_d = '0;
                if (bus.start_pulse) state_d = RUN;
            end
            RUN: begin
                if (bus.crash) begin
                    state_d = FROZEN;
                end else if (tick) begin
                    for (int i = 0; i < 2; i++) begin
                        if (valid_q[i]) begin
                            if (x_q[i] >= {5'd0, speed_q}) begin
                                x_d[i] = x_q[i] - {5'd0, speed_q};
                            end else begin
                                valid_d[i] = 1'b0;
                                x_d[i]     = '0;
                            end
                        end
                    end
                    gap_d = gap_sum[8] ? 8'hFF : gap_sum[7:0];
                    // Free slots are judged on valid_q, so a slot expiring this tick waits a tick.
                    if (gap_q >= MIN_GAP && lfsr_q[1:0] == 2'b00 && valid_q != 2'b11) begin
                        spawn_slot         = valid_q[0];
                        valid_d[spawn_slot] = 1'b1;
                        x_d[spawn_slot]     = X_START;
                        type_d[spawn_slot]  = lfsr_q[3:2];
                        gap_d               = '0;
                    end
                    if (tick_cnt_q == SPEED_STEP - 10'd1) begin
                        tick_cnt_d = '0;
                        if (speed_q < MAX_SPEED) speed_d = speed_q + 3'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 10'd1;
                    end
                end
            end
            FROZEN: begin
                if (bus.start_pulse) begin
                    valid_d    = '0;
                    x_d        = '0;
                    type_d     = '0;
                    speed_d    = 3'd1;
                    gap_d      = '0;
                    tick_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            x_q        <= '0;
            type_q     <= '0;
            speed_q    <= 3'd1;
            lfsr_q     <= LFSR_SEED;
            gap_q      <= '0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            type_q     <= type_d;
            speed_q    <= speed_d;
            lfsr_q     <= lfsr_d;
            gap_q      <= gap_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.obs_valid = valid_q;
    assign bus.obs0_x    = x_q[0];
    assign bus.obs1_x    = x_q[1];
    assign bus.obs0_type = type_q[0];
    assign bus.obs1_type = type_q[1];
    assign bus.speed     = speed_q;
    assign bus.running   = (state_q == RUN);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: fixed expectations at key points plus a
// small behavioural model that is compared against the outputs after every cycle.
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic half_tick = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   run_ticks;
    int   spawn_n;
    int   exp_type;
    int   waited;
    int   l;

    int m_state, m_gap, m_tick_cnt, m_speed, m_lfsr;
    int m_valid[2];
    int m_x[2];
    int m_type[2];

    obstacle_scheduler_if bus ();

    obstacle_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int lfsrNext(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            m_x[i]     = 0;
            m_type[i]  = 0;
        end
        m_speed    = 1;
        m_gap      = 0;
        m_tick_cnt = 0;
    endtask

    task automatic modelReset();
        modelClear();
        m_state = 0;
        m_lfsr  = 'hA5;
    endtask

    task automatic modelStep(input bit t0, input bit st, input bit cr);
        int  old_lfsr;
        int  old_gap;
        int  slot;
        bit  free0;
        bit  free1;
        if (!rst_n) begin
            modelReset();
            return;
        end
        old_lfsr = m_lfsr;
        old_gap  = m_gap;
        if (t0) m_lfsr = lfsrNext(m_lfsr);
        case (m_state)
            0: begin
                modelClear();
                if (st) m_state = 1;
            end
            1: begin
                if (cr) begin
                    m_state = 2;
                end else if (t0) begin
                    free0 = (m_valid[0] == 0);
                    free1 = (m_valid[1] == 0);
                    for (int i = 0; i < 2; i++) begin
                        if (m_valid[i] != 0) begin
                            if (m_x[i] < m_speed) begin
                                m_valid[i] = 0;
                                m_x[i]     = 0;
                            end else begin
                                m_x[i] = m_x[i] - m_speed;
                            end
                        end
                    end
                    m_gap = (m_gap + m_speed > 255) ? 255 : m_gap + m_speed;
                    if (old_gap >= 48 && (old_lfsr & 3) == 0 && (free0 || free1)) begin
                        slot          = free0 ? 0 : 1;
                        m_valid[slot] = 1;
                        m_x[slot]     = 160;
                        m_type[slot]  = (old_lfsr >> 2) & 3;
                        m_gap         = 0;
                    end
                    m_tick_cnt++;
                    if (m_tick_cnt == 512) begin
                        m_tick_cnt = 0;
                        if (m_speed < 4) m_speed++;
                    end
                end
            end
            default: begin
                if (st) begin
                    modelClear();
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic checkModel();
        checkOutput("mdl_valid", bus.obs_valid, m_valid[1] * 2 + m_valid[0]);
        checkOutput("mdl_x0", bus.obs0_x, m_x[0]);
        checkOutput("mdl_x1", bus.obs1_x, m_x[1]);
        checkOutput("mdl_type0", bus.obs0_type, m_type[0]);
        checkOutput("mdl_type1", bus.obs1_type, m_type[1]);
        checkOutput("mdl_speed", bus.speed, m_speed);
        checkOutput("mdl_running", bus.running, (m_state == 1) ? 1 : 0);
    endtask

    task automatic applyStimulus(input bit t0, input bit st, input bit cr);
        if (t0) half_tick = ~half_tick;
        bus.game_tick   = {half_tick & t0, t0};
        bus.start_pulse = st;
        bus.crash       = cr;
        @(posedge clk);
        modelStep(t0, st, cr);
        @(negedge clk);
        bus.game_tick   = 2'b00;
        bus.start_pulse = 1'b0;
        bus.crash       = 1'b0;
    endtask

    initial begin
        bus.game_tick   = 2'b00;
        bus.start_pulse = 1'b0;
        bus.crash       = 1'b0;
        rst_n           = 1'b0;
        modelReset();
        @(negedge clk);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        rst_n = 1'b1;
        $display("[TB] reset released");

        checkOutput("rst_valid", bus.obs_valid, 0);
        checkOutput("rst_x0", bus.obs0_x, 0);
        checkOutput("rst_type0", bus.obs0_type, 0);
        checkOutput("rst_speed", bus.speed, 1);
        checkOutput("rst_running", bus.running, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0);
            checkModel();
        end
        checkOutput("idle_valid", bus.obs_valid, 0);
        checkOutput("idle_speed", bus.speed, 1);
        checkOutput("idle_running", bus.running, 0);

        applyStimulus(0, 1, 0);
        checkOutput("start_running", bus.running, 1);
        checkOutput("start_valid", bus.obs_valid, 0);

        // First spawn: gap seen by tick n is n-1, so n >= 49 with lfsr[1:0] == 0.
        spawn_n  = 300;
        exp_type = 0;
        l        = m_lfsr;
        for (int n = 1; n <= 300; n++) begin
            if (n >= 49 && (l & 3) == 0) begin
                spawn_n  = n;
                exp_type = (l >> 2) & 3;
                break;
            end
            l = lfsrNext(l);
        end
        $display("[TB] first spawn expected on tick %0d", spawn_n);
        for (int n = 1; n <= spawn_n; n++) begin
            applyStimulus(1, 0, 0);
            checkModel();
            if (n < spawn_n) checkOutput("no_early_spawn", bus.obs_valid, 0);
        end
        checkOutput("spawn_valid", bus.obs_valid, 1);
        checkOutput("spawn_x", bus.obs0_x, 160);
        checkOutput("spawn_type", bus.obs0_type, exp_type);

        run_ticks = spawn_n;
        while (run_ticks < 4096) begin
            run_ticks++;
            applyStimulus(1, run_ticks == 700, 0);
            checkModel();
            if (run_ticks == 511)  checkOutput("speed_t511", bus.speed, 1);
            if (run_ticks == 512)  checkOutput("speed_t512", bus.speed, 2);
            if (run_ticks == 1024) checkOutput("speed_t1024", bus.speed, 3);
            if (run_ticks == 1536) checkOutput("speed_t1536", bus.speed, 4);
            if (run_ticks == 2048) checkOutput("speed_t2048", bus.speed, 4);
            if (run_ticks == 4096) checkOutput("speed_t4096", bus.speed, 4);
            if (run_ticks == 700)  checkOutput("start_in_run", bus.running, 1);
            if (run_ticks % 3 == 0) begin
                applyStimulus(0, 0, 0);
                checkModel();
            end
        end

        waited = 0;
        while (!(m_valid[0] == 1 && m_x[0] == 100) && waited < 1000) begin
            applyStimulus(1, 0, 0);
            checkModel();
            waited++;
        end
        checkOutput("pre_crash_x0", bus.obs0_x, 100);

        applyStimulus(1, 0, 1);
        checkModel();
        checkOutput("crash_x0", bus.obs0_x, 100);
        checkOutput("crash_running", bus.running, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, (i % 4) == 0);
            checkModel();
            checkOutput("frozen_x0", bus.obs0_x, 100);
        end
        checkOutput("frozen_speed", bus.speed, 4);
        checkOutput("frozen_running", bus.running, 0);

        applyStimulus(1, 1, 0);
        checkModel();
        checkOutput("restart_running", bus.running, 1);
        checkOutput("restart_valid", bus.obs_valid, 0);
        checkOutput("restart_speed", bus.speed, 1);
        checkOutput("restart_x0", bus.obs0_x, 0);
        for (int i = 1; i <= 48; i++) begin
            applyStimulus(1, 0, 0);
            checkModel();
            checkOutput("restart_no_spawn", bus.obs_valid, 0);
        end
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1, 0, 0);
            checkModel();
        end

        rst_n = 1'b0;
        applyStimulus(1, 0, 0);
        rst_n = 1'b1;
        checkOutput("midrst_valid", bus.obs_valid, 0);
        checkOutput("midrst_x0", bus.obs0_x, 0);
        checkOutput("midrst_x1", bus.obs1_x, 0);
        checkOutput("midrst_type1", bus.obs1_type, 0);
        checkOutput("midrst_speed", bus.speed, 1);
        checkOutput("midrst_running", bus.running, 0);
        checkModel();

        applyStimulus(0, 1, 0);
        checkModel();
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1, 0, 0);
            checkModel();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
